reg_file_sb: RTL and testbench

Parametrised successor to the pipelined processor's register file: two combinational read ports, one synchronous write port, optional write-to-read bypass, optional hardwired-zero register 0, and a per-register busy scoreboard. The decode stage reserves a destination register when an instruction issues. Writeback clears the reservation. Decode uses the busy flags to detect RAW hazards without a separate hazard table.

---
 rtl/reg_file_sb.sv | 108 ++++++++++
 tb/tb_reg_file_sb.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_sb
// Description : Register file with a per-register busy scoreboard.
//               - Two combinational read ports (rd1/rd2) with busy flags
//                 (busy1/busy2) for RAW hazard detection in decode.
//               - One synchronous write port (write/wr/wd). A write clears
//                 the busy bit of its target register.
//               - One synchronous reserve port (reserve/rsv). A reserve
//                 marks its register busy. When a reserve and a write hit
//                 the same register in one cycle, the reserve wins.
//               - Optional write-to-read bypass (BYPASS) forwards data and
//                 the cleared busy flag in the same cycle.
//               - Optional hardwired-zero register 0 (ZERO_REG).
// Ports       : clk, reset (sync, active-high)
//               write, wr, wd               : write port
//               pr1, pr2 -> rd1, rd2        : read ports
//               reserve, rsv                : scoreboard reservation
//               busy1, busy2                : pending-producer flags
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_sb #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic [ADDR_W-1:0] wr,
    input  logic [WIDTH-1:0]  wd,
    input  logic [ADDR_W-1:0] pr1,
    input  logic [ADDR_W-1:0] pr2,
    output logic [WIDTH-1:0]  rd1,
    output logic [WIDTH-1:0]  rd2,
    input  logic              reserve,
    input  logic [ADDR_W-1:0] rsv,
    output logic              busy1,
    output logic              busy2
);

    localparam int  c_DEPTH  = 2 ** ADDR_W;
    localparam bit  c_ZERO   = (ZERO_REG != 0);
    localparam bit  c_BYPASS = (BYPASS != 0);

    logic [WIDTH-1:0] r_mem [c_DEPTH];
    logic [c_DEPTH-1:0] r_bsy;

    logic w_we;
    logic w_re;
    logic w_fwd1;
    logic w_fwd2;

    // Writes/reserves to the hardwired-zero register and anything issued
    // during reset are dropped before they reach the state.
    assign w_we = write   & ~reset & ~(c_ZERO & (wr  == '0));
    assign w_re = reserve & ~reset & ~(c_ZERO & (rsv == '0));

    // Bypass only uses the effective write, so it is inactive under reset.
    assign w_fwd1 = c_BYPASS & w_we & (wr == pr1);
    assign w_fwd2 = c_BYPASS & w_we & (wr == pr2);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_bsy <= '0;
        end else begin
            if (w_we) begin
                r_mem[wr] <= wd;
                r_bsy[wr] <= 1'b0;
            end
            // Ordered after the write clear: a new producer issued in the
            // same cycle as the old one retires keeps the register busy.
            if (w_re) begin
                r_bsy[rsv] <= 1'b1;
            end
        end
    end

    always_comb begin
        rd1   = r_mem[pr1];
        busy1 = r_bsy[pr1];
        if (c_ZERO && (pr1 == '0)) begin
            rd1   = '0;
            busy1 = 1'b0;
        end else if (w_fwd1) begin
            rd1   = wd;
            busy1 = 1'b0;
        end
    end

    always_comb begin
        rd2   = r_mem[pr2];
        busy2 = r_bsy[pr2];
        if (c_ZERO && (pr2 == '0)) begin
            rd2   = '0;
            busy2 = 1'b0;
        end else if (w_fwd2) begin
            rd2   = wd;
            busy2 = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_sb
// Description : Scoreboard bench for reg_file_sb. Two instances share the
//               stimulus: the default build (ZERO_REG=1, BYPASS=1) and a
//               plain build (ZERO_REG=0, BYPASS=0). Each cycle the stimulus
//               process drives inputs and queues the outputs it expects;
//               a monitor on the falling edge pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_sb;

    localparam int c_WIDTH  = 32;
    localparam int c_ADDR_W = 5;

    logic                clk;
    logic                reset;
    logic                write;
    logic [c_ADDR_W-1:0] wr;
    logic [c_WIDTH-1:0]  wd;
    logic [c_ADDR_W-1:0] pr1;
    logic [c_ADDR_W-1:0] pr2;
    logic                reserve;
    logic [c_ADDR_W-1:0] rsv;

    logic [c_WIDTH-1:0]  rd1_a, rd2_a, rd1_b, rd2_b;
    logic                busy1_a, busy2_a, busy1_b, busy2_b;

    reg_file_sb #(.WIDTH(c_WIDTH), .ADDR_W(c_ADDR_W), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .write(write), .wr(wr), .wd(wd),
        .pr1(pr1), .pr2(pr2), .rd1(rd1_a), .rd2(rd2_a),
        .reserve(reserve), .rsv(rsv), .busy1(busy1_a), .busy2(busy2_a)
    );

    reg_file_sb #(.WIDTH(c_WIDTH), .ADDR_W(c_ADDR_W), .ZERO_REG(0), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .write(write), .wr(wr), .wd(wd),
        .pr1(pr1), .pr2(pr2), .rd1(rd1_b), .rd2(rd2_b),
        .reserve(reserve), .rsv(rsv), .busy1(busy1_b), .busy2(busy2_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output selectors: 0..3 default build, 4..7 plain build.
    localparam int c_RD1 = 0, c_RD2 = 1, c_B1 = 2, c_B2 = 3;
    localparam int c_NB  = 4;

    int          sel_q [$];
    logic [31:0] exp_q [$];
    int          tst_q [$];

    int checks   = 0;
    int failures = 0;
    int test_id  = 0;

    function automatic string sel_name(input int s);
        case (s)
            0: return "rd1";
            1: return "rd2";
            2: return "busy1";
            3: return "busy2";
            4: return "nb.rd1";
            5: return "nb.rd2";
            6: return "nb.busy1";
            default: return "nb.busy2";
        endcase
    endfunction

    function automatic logic [31:0] actual(input int s);
        case (s)
            0: return rd1_a;
            1: return rd2_a;
            2: return {31'd0, busy1_a};
            3: return {31'd0, busy2_a};
            4: return rd1_b;
            5: return rd2_b;
            6: return {31'd0, busy1_b};
            default: return {31'd0, busy2_b};
        endcase
    endfunction

    // Monitor: compare every expectation queued for the current cycle.
    always @(negedge clk) begin
        while (sel_q.size() > 0) begin
            int          s;
            logic [31:0] e;
            logic [31:0] a;
            int          t;
            s = sel_q.pop_front();
            e = exp_q.pop_front();
            t = tst_q.pop_front();
            a = actual(s);
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL test%0d %s: got %h expected %h", t, sel_name(s), a, e);
            end
        end
    end

    task automatic drive(input logic r, input logic w, input logic [c_ADDR_W-1:0] a,
                         input logic [31:0] d, input logic [c_ADDR_W-1:0] p1,
                         input logic [c_ADDR_W-1:0] p2, input logic res,
                         input logic [c_ADDR_W-1:0] ra);
        @(posedge clk);
        #1;
        reset = r; write = w; wr = a; wd = d;
        pr1 = p1; pr2 = p2; reserve = res; rsv = ra;
    endtask

    task automatic expect_out(input int s, input logic [31:0] v);
        sel_q.push_back(s);
        exp_q.push_back(v);
        tst_q.push_back(test_id);
    endtask

    initial begin
        reset = 1'b1; write = 1'b0; wr = '0; wd = '0;
        pr1 = '0; pr2 = '0; reserve = 1'b0; rsv = '0;

        // Initial reset, then reset-state outputs.
        test_id = 0;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 5, 31, 0, 0);
        expect_out(c_RD1, 0); expect_out(c_RD2, 0);
        expect_out(c_B1, 0);  expect_out(c_B2, 0);
        expect_out(c_NB + c_RD2, 0); expect_out(c_NB + c_B2, 0);

        // 1: preload $16 and reserve $3, then reset clears both.
        test_id = 1;
        drive(0, 1, 16, 32'hFFFF_FFFF, 16, 3, 1, 3);
        expect_out(c_RD1, 32'hFFFF_FFFF); expect_out(c_B2, 0);
        expect_out(c_NB + c_RD1, 0);      expect_out(c_NB + c_B2, 0);
        drive(0, 0, 0, 0, 16, 3, 0, 0);
        expect_out(c_RD1, 32'hFFFF_FFFF); expect_out(c_B2, 1);
        expect_out(c_NB + c_RD1, 32'hFFFF_FFFF); expect_out(c_NB + c_B2, 1);
        drive(1, 0, 0, 0, 16, 3, 0, 0);
        expect_out(c_RD1, 32'hFFFF_FFFF);
        drive(0, 0, 0, 0, 16, 3, 0, 0);
        expect_out(c_RD1, 0); expect_out(c_B2, 0);
        expect_out(c_NB + c_RD1, 0); expect_out(c_NB + c_B2, 0);
        drive(0, 0, 0, 0, 3, 16, 0, 0);
        expect_out(c_B1, 0); expect_out(c_RD2, 0);

        // 2: write with bypass; plain build sees old data until the edge.
        test_id = 2;
        drive(0, 1, 16, 32'hDEAD_BEEF, 16, 16, 0, 0);
        expect_out(c_RD1, 32'hDEAD_BEEF); expect_out(c_NB + c_RD1, 0);
        drive(0, 0, 0, 0, 16, 16, 0, 0);
        expect_out(c_RD1, 32'hDEAD_BEEF); expect_out(c_NB + c_RD1, 32'hDEAD_BEEF);

        // 3: register 0 write + reserve.
        test_id = 3;
        drive(0, 1, 0, 32'h1234_5678, 0, 0, 1, 0);
        expect_out(c_RD1, 0); expect_out(c_B1, 0);
        expect_out(c_NB + c_RD1, 0); expect_out(c_NB + c_B1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        expect_out(c_RD1, 0); expect_out(c_B1, 0);
        expect_out(c_NB + c_RD1, 32'h1234_5678); expect_out(c_NB + c_B1, 1);

        // 4: scoreboard lifecycle on $7.
        test_id = 4;
        drive(0, 0, 0, 0, 0, 7, 1, 7);
        expect_out(c_B2, 0); expect_out(c_NB + c_B2, 0);
        drive(0, 0, 0, 0, 0, 7, 0, 0);
        expect_out(c_B2, 1); expect_out(c_NB + c_B2, 1);
        drive(0, 1, 7, 32'd5, 0, 7, 0, 0);
        expect_out(c_B2, 0); expect_out(c_RD2, 5);
        expect_out(c_NB + c_B2, 1); expect_out(c_NB + c_RD2, 0);
        drive(0, 0, 0, 0, 7, 7, 0, 0);
        expect_out(c_B1, 0); expect_out(c_B2, 0);
        expect_out(c_RD1, 5); expect_out(c_RD2, 5);
        expect_out(c_NB + c_B2, 0); expect_out(c_NB + c_RD2, 5);

        // 5: $9 busy, then write and reserve $9 on the same edge.
        test_id = 5;
        drive(0, 0, 0, 0, 9, 0, 1, 9);
        drive(0, 1, 9, 32'hCAFE_F00D, 9, 0, 1, 9);
        expect_out(c_B1, 0); expect_out(c_RD1, 32'hCAFE_F00D);
        expect_out(c_NB + c_B1, 1); expect_out(c_NB + c_RD1, 0);
        drive(0, 0, 0, 0, 9, 0, 0, 0);
        expect_out(c_B1, 1); expect_out(c_RD1, 32'hCAFE_F00D);
        expect_out(c_NB + c_B1, 1); expect_out(c_NB + c_RD1, 32'hCAFE_F00D);

        // 6: reset overrides a write and clears the pending $9 reservation.
        test_id = 6;
        drive(1, 1, 4, 32'hA5A5_A5A5, 4, 9, 0, 0);
        expect_out(c_RD1, 0); expect_out(c_NB + c_RD1, 0);
        drive(0, 0, 0, 0, 4, 9, 0, 0);
        expect_out(c_RD1, 0); expect_out(c_B2, 0);
        expect_out(c_NB + c_RD1, 0); expect_out(c_NB + c_B2, 0);
        drive(0, 1, 9, 32'd1, 4, 9, 0, 0);
        expect_out(c_B2, 0); expect_out(c_NB + c_B2, 0);
        drive(0, 0, 0, 0, 4, 9, 0, 0);
        expect_out(c_B2, 0); expect_out(c_RD2, 1);
        expect_out(c_NB + c_B2, 0); expect_out(c_NB + c_RD2, 1);

        @(negedge clk);
        #1;
        checks++;
        if (sel_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", sel_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
